// File: rtl/ram256_dff.sv
// 256-word single-port RAM with byte-lane write enables and registered read-first output.
// Storage is either latch cells (written in the clock low phase) or flip-flops.
module ram256_dff #(
  parameter int unsigned USE_LATCH = 1,
  parameter int unsigned WSIZE     = 1
) (
`ifdef USE_POWER_PINS
  inout  wire                   VPWR,
  inout  wire                   VGND,
`endif
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  EN0,
  input  logic [WSIZE-1:0]      WE0,
  input  logic [7:0]            A0,
  input  logic [8*WSIZE-1:0]    Di0,
  output logic [8*WSIZE-1:0]    Do0
);

  localparam int unsigned DW    = 8 * WSIZE;
  localparam int unsigned DEPTH = 256;

  logic [DW-1:0] words [DEPTH];

  // Registered read port; read-first because words[] only changes after the edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      Do0 <= '0;
    end else if (EN0) begin
      Do0 <= words[A0];
    end
  end

  if (USE_LATCH != 0) begin : g_latch
    logic [WSIZE-1:0] wr_q;
    logic [7:0]       wa_q;
    logic [DW-1:0]    wd_q;

    // Stage the write; latches open during the following low phase, after the read has sampled.
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        wr_q <= '0;
        wa_q <= '0;
        wd_q <= '0;
      end else begin
        wr_q <= EN0 ? WE0 : '0;
        wa_q <= A0;
        wd_q <= Di0;
      end
    end

    for (genvar w = 0; w < int'(DEPTH); w++) begin : g_row
      logic [DW-1:0]    row;
      logic [WSIZE-1:0] lane_en_c;

      // Staged controls only change while CLK is high, so these enables cannot glitch.
      assign lane_en_c = (wa_q == 8'(w) && !CLK) ? wr_q : '0;

      always_latch begin
        for (int l = 0; l < int'(WSIZE); l++) begin
          if (lane_en_c[l]) row[8*l +: 8] <= wd_q[8*l +: 8];
        end
      end

      assign words[w] = row;
    end
  end else begin : g_flop
    logic [DW-1:0] mem [DEPTH];

    // Array is never cleared; RST only suppresses the access at that edge.
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
      end else if (EN0) begin
        for (int l = 0; l < int'(WSIZE); l++) begin
          if (WE0[l]) mem[A0][8*l +: 8] <= Di0[8*l +: 8];
        end
      end
    end

    for (genvar w = 0; w < int'(DEPTH); w++) begin : g_row
      assign words[w] = mem[w];
    end
  end

endmodule

// File: tb/tb_ram256_dff.sv
// Directed bench for ram256_dff (WSIZE=2): flop and latch builds driven in lockstep.
module tb_ram256_dff;

  logic        clk;
  logic        rst;
  logic        en0;
  logic [1:0]  we0;
  logic [7:0]  a0;
  logic [15:0] di0;
  logic [15:0] do_ff;
  logic [15:0] do_lat;

  int n_tests;
  int n_fail;

  ram256_dff #(.USE_LATCH(0), .WSIZE(2)) u_ff (
    .CLK(clk), .RST(rst), .EN0(en0), .WE0(we0), .A0(a0), .Di0(di0), .Do0(do_ff)
  );

  ram256_dff #(.USE_LATCH(1), .WSIZE(2)) u_lat (
    .CLK(clk), .RST(rst), .EN0(en0), .WE0(we0), .A0(a0), .Di0(di0), .Do0(do_lat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [1:0]  we;
    logic [7:0]  a;
    logic [15:0] di;
    logic        chk;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [15:0] exp);
    n_tests++;
    if (do_ff !== exp) begin
      n_fail++;
      $display("FAIL %s (flop): got %h expected %h", name, do_ff, exp);
    end
    n_tests++;
    if (do_lat !== exp) begin
      n_fail++;
      $display("FAIL %s (latch): got %h expected %h", name, do_lat, exp);
    end
  endtask

  // Drive after a negedge, clock once, return at the next negedge.
  task automatic cyc(input logic en, input logic [1:0] we, input logic [7:0] a, input logic [15:0] di);
    en0 = en;
    we0 = we;
    a0  = a;
    di0 = di;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b0;
    en0 = 1'b0;
    we0 = 2'b00;
    a0  = 8'h00;
    di0 = 16'h0000;

    // Async reset before any clock edge.
    #2 rst = 1'b1;
    #1 check("reset_async", 16'h0000);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) cyc(1'b0, 2'b11, 8'h00, 16'hFFFF);
    check("reset_idle", 16'h0000);

    // Fill then read back.
    for (int i = 0; i < 256; i++) cyc(1'b1, 2'b11, 8'(i), 16'(i));
    for (int i = 0; i < 256; i++) begin
      cyc(1'b1, 2'b00, 8'(i), 16'hDEAD);
      check($sformatf("fill_rd_%0d", i), 16'(i));
    end

    vecs[0]  = '{1'b1, 2'b11, 8'h10, 16'hA5A5, 1'b1, 16'h0010};
    vecs[1]  = '{1'b1, 2'b01, 8'h10, 16'h1234, 1'b1, 16'hA5A5};
    vecs[2]  = '{1'b1, 2'b00, 8'h10, 16'h0000, 1'b1, 16'hA534};
    vecs[3]  = '{1'b1, 2'b11, 8'h03, 16'h0001, 1'b1, 16'h0003};
    vecs[4]  = '{1'b1, 2'b11, 8'h03, 16'hBEEF, 1'b1, 16'h0001};
    vecs[5]  = '{1'b1, 2'b00, 8'h03, 16'h0000, 1'b1, 16'hBEEF};
    vecs[6]  = '{1'b1, 2'b00, 8'h05, 16'h0000, 1'b1, 16'h0005};
    vecs[7]  = '{1'b0, 2'b11, 8'h05, 16'hFFFF, 1'b1, 16'h0005};
    vecs[8]  = '{1'b1, 2'b00, 8'h05, 16'h0000, 1'b1, 16'h0005};
    vecs[9]  = '{1'b1, 2'b11, 8'hFF, 16'h5A5A, 1'b1, 16'h00FF};
    vecs[10] = '{1'b1, 2'b10, 8'h07, 16'hAB00, 1'b1, 16'h0007};
    vecs[11] = '{1'b1, 2'b00, 8'h07, 16'h0000, 1'b1, 16'hAB07};

    foreach (vecs[i]) begin
      cyc(vecs[i].en, vecs[i].we, vecs[i].a, vecs[i].di);
      if (vecs[i].chk) check($sformatf("vec_%0d", i), vecs[i].exp);
    end

    // Input changes between edges must not disturb Do0.
    a0 = 8'h10;
    #2 check("between_edges", 16'hAB07);

    // Mid-cycle reset: Do0 clears, the access at the reset edge is dropped, array retained.
    @(negedge clk);
    en0 = 1'b1; we0 = 2'b11; a0 = 8'hFF; di0 = 16'h0000;
    #1 rst = 1'b1;
    #1 check("rst_pulse", 16'h0000);
    @(posedge clk);
    @(negedge clk);
    check("rst_held", 16'h0000);
    rst = 1'b0;
    cyc(1'b1, 2'b00, 8'hFF, 16'h0000);
    check("rst_retain_ff", 16'h5A5A);
    cyc(1'b1, 2'b00, 8'h10, 16'h0000);
    check("rst_retain_10", 16'hA534);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
